// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Constants and types shared by the fetch/decode boundary logic.
//               - DATA_WIDTH   : width of PC and instruction words
//               - PC_INCREMENT : constant added to a captured PC
//               - NOP_INSTR    : instruction shown to decode when nothing valid
//               - occ_state_e  : occupancy of the two-entry skid buffer
//               - if_id_entry_t: one buffered {pc, pc_plus4, instr} record
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int                  DATA_WIDTH   = 32;
    localparam logic [DATA_WIDTH-1:0] PC_INCREMENT = 32'd4;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0000;

    // Occupancy of the buffer; the encoding is also the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] instr;
    } if_id_entry_t;

    // Build an entry from a fetched {PC, instruction} pair. The sum wraps
    // modulo 2^DATA_WIDTH, so the last word of the address space yields 0.
    function automatic if_id_entry_t make_entry(
        input logic [DATA_WIDTH-1:0] pc,
        input logic [DATA_WIDTH-1:0] instr
    );
        if_id_entry_t e;
        e.pc       = pc;
        e.pc_plus4 = pc + PC_INCREMENT;
        e.instr    = instr;
        return e;
    endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/if_id_entry_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_entry_reg
// Description : One 96-bit {pc, pc_plus4, instr} storage slot of the IF/ID
//               buffer, with load enable and synchronous clear.
// Ports       : clk_i   - clock
//               clear_i - synchronous clear to all-zero (wins over load)
//               load_i  - capture d_i on this edge
//               d_i     - entry to capture
//               q_o     - stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_entry_reg
    import pipeline_pkg::*;
(
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  if_id_entry_t d_i,
    output if_id_entry_t q_o
);

    if_id_entry_t entry_q;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            entry_q <= '0;
        end else if (load_i) begin
            entry_q <= d_i;
        end
    end

    assign q_o = entry_q;

endmodule : if_id_entry_reg
`default_nettype wire

// File: rtl/if_id_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_buffer
// Description : Fetch-to-decode boundary register. Captures {PC, instruction}
//               plus PC+4 and hands them to decode through a valid/ready
//               handshake using a two-entry skid buffer (head + skid), so
//               streaming runs at full rate and decode backpressure never
//               loses or duplicates an entry. Flush squashes everything held.
// Ports       : Clk, Reset          - clock, synchronous active-high reset
//               PCIn, InstructionIn - fetched PC and instruction word
//               InValid / InReady   - upstream handshake
//               Flush               - drop all buffered entries
//               PCOut, PCPlus4Out,
//               InstructionOut      - head entry (zero / NOP when not valid)
//               OutValid / OutReady - downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage_buffer
    import pipeline_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] PCIn,
    input  logic [DATA_WIDTH-1:0] InstructionIn,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic                  Flush,
    output logic [DATA_WIDTH-1:0] PCOut,
    output logic [DATA_WIDTH-1:0] PCPlus4Out,
    output logic [DATA_WIDTH-1:0] InstructionOut,
    output logic                  OutValid,
    input  logic                  OutReady
);

    occ_state_e   state_q;
    occ_state_e   state_d;

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_accept;
    logic         w_consume;
    logic         w_clear;
    logic         w_head_load;
    logic         w_skid_load;
    if_id_entry_t w_new_entry;
    if_id_entry_t w_head_d;
    if_id_entry_t w_head_q;
    if_id_entry_t w_skid_q;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign w_accept  = InValid & w_in_ready;
    assign w_consume = w_out_valid & OutReady;

    // Both slots are wiped on reset and on flush, so nothing stale can be
    // promoted to the head later.
    assign w_clear   = Reset | Flush;

    // PC+4 is formed once at capture and travels with the entry.
    assign w_new_entry = make_entry(PCIn, InstructionIn);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (Flush) begin
            // A same-cycle accept is discarded; a same-cycle consume has
            // already been seen by decode, so there is nothing to undo.
            state_d = OCC_EMPTY;
        end else begin
            unique case (state_q)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && !w_consume) begin
                        state_d = OCC_FULL;
                    end else if (!w_accept && w_consume) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (w_consume) begin
                        state_d = OCC_ONE;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (state-only, so InReady has no path from OutReady)
    // ------------------------------------------------------------------
    always_comb begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
        unique case (state_q)
            OCC_EMPTY: begin
                w_out_valid = 1'b0;
                w_in_ready  = 1'b1;
            end
            OCC_ONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = 1'b1;
            end
            OCC_FULL: begin
                w_out_valid = 1'b1;
                w_in_ready  = 1'b0;
            end
            default: begin
                w_out_valid = 1'b0;
                w_in_ready  = 1'b0;
            end
        endcase
        // Nothing is accepted while reset is held.
        if (Reset) begin
            w_in_ready = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath steering
    //   head loads : new entry into EMPTY, new entry replacing a consumed
    //                head in ONE, or the skid entry moving up from FULL.
    //   skid loads : new entry arriving in ONE while the head is held.
    // ------------------------------------------------------------------
    always_comb begin
        w_head_load = 1'b0;
        w_skid_load = 1'b0;
        w_head_d    = w_new_entry;
        unique case (state_q)
            OCC_EMPTY: begin
                w_head_load = w_accept;
            end
            OCC_ONE: begin
                w_head_load = w_accept & w_consume;
                w_skid_load = w_accept & ~w_consume;
            end
            OCC_FULL: begin
                w_head_load = w_consume;
                w_head_d    = w_skid_q;
            end
            default: begin
                w_head_load = 1'b0;
            end
        endcase
    end

    if_id_entry_reg u_head (
        .clk_i   (Clk),
        .clear_i (w_clear),
        .load_i  (w_head_load),
        .d_i     (w_head_d),
        .q_o     (w_head_q)
    );

    if_id_entry_reg u_skid (
        .clk_i   (Clk),
        .clear_i (w_clear),
        .load_i  (w_skid_load),
        .d_i     (w_new_entry),
        .q_o     (w_skid_q)
    );

    // ------------------------------------------------------------------
    // Outputs: an invalid head always shows zero PCs and a NOP, whatever
    // happens to be sitting in storage.
    // ------------------------------------------------------------------
    assign InReady        = w_in_ready;
    assign OutValid       = w_out_valid;
    assign PCOut          = w_out_valid ? w_head_q.pc       : '0;
    assign PCPlus4Out     = w_out_valid ? w_head_q.pc_plus4 : '0;
    assign InstructionOut = w_out_valid ? w_head_q.instr    : NOP_INSTR;

endmodule : if_id_stage_buffer
`default_nettype wire

// File: tb/tb_if_id_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage_buffer
// Description : Self-checking bench for if_id_stage_buffer. A queue-based
//               reference model of the buffer is compared with the DUT on
//               every negative clock edge; directed scenarios add literal
//               expectations, followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage_buffer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PCIn = '0;
    logic [31:0] InstructionIn = '0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic        Flush = 1'b0;
    logic [31:0] PCOut;
    logic [31:0] PCPlus4Out;
    logic [31:0] InstructionOut;
    logic        OutValid;
    logic        OutReady = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    if_id_stage_buffer dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PCIn           (PCIn),
        .InstructionIn  (InstructionIn),
        .InValid        (InValid),
        .InReady        (InReady),
        .Flush          (Flush),
        .PCOut          (PCOut),
        .PCPlus4Out     (PCPlus4Out),
        .InstructionOut (InstructionOut),
        .OutValid       (OutValid),
        .OutReady       (OutReady)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a FIFO of at most two entries.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pp4;
        logic [31:0] instr;
    } ent_t;

    ent_t mq[$];
    bit   model_init = 1'b0;

    always @(posedge Clk) begin : model
        bit acc;
        bit con;
        ent_t e;
        acc = InValid && !Reset && (mq.size() < 2);
        con = (mq.size() > 0) && OutReady;
        if (Reset) begin
            mq.delete();
            model_init = 1'b1;
        end else if (Flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) begin
                e.pc    = PCIn;
                e.pp4   = PCIn + 32'd4;
                e.instr = InstructionIn;
                mq.push_back(e);
            end
        end
    end

    // Compare process: outputs are settled at the falling edge.
    always @(negedge Clk) begin : compare
        if (model_init) begin
            chk("OutValid", {31'd0, OutValid}, {31'd0, mq.size() > 0});
            chk("InReady", {31'd0, InReady}, {31'd0, (!Reset && mq.size() < 2)});
            chk("PCOut", PCOut, (mq.size() > 0) ? mq[0].pc : 32'd0);
            chk("PCPlus4Out", PCPlus4Out, (mq.size() > 0) ? mq[0].pp4 : 32'd0);
            chk("InstructionOut", InstructionOut, (mq.size() > 0) ? mq[0].instr : 32'd0);
        end
    end

    // Drive one cycle's inputs, then return 1 ns after the capturing edge.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                        input bit ordy, input bit fl, input bit rst);
        @(negedge Clk);
        #1;
        InValid       = v;
        PCIn          = pc;
        InstructionIn = ins;
        OutReady      = ordy;
        Flush         = fl;
        Reset         = rst;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // 1: reset held two cycles with InValid high
        for (int i = 0; i < 2; i++) begin
            step(1, 32'h100, 32'hDEAD, 1, 0, 1);
            chk("rst_OutValid", {31'd0, OutValid}, 32'd0);
            chk("rst_InReady", {31'd0, InReady}, 32'd0);
            chk("rst_Instr", InstructionOut, 32'h0);
        end
        step(0, 0, 0, 1, 0, 0);
        chk("rel_InReady", {31'd0, InReady}, 32'd1);
        chk("rel_OutValid", {31'd0, OutValid}, 32'd0);

        // 2: streaming with OutReady=1
        step(1, 32'h0, 32'hA, 1, 0, 0);
        chk("s0_pc", PCOut, 32'h0);
        chk("s0_pp4", PCPlus4Out, 32'h4);
        chk("s0_ins", InstructionOut, 32'hA);
        step(1, 32'h4, 32'hB, 1, 0, 0);
        chk("s1_pp4", PCPlus4Out, 32'h8);
        chk("s1_ins", InstructionOut, 32'hB);
        step(1, 32'h8, 32'hC, 1, 0, 0);
        chk("s2_pp4", PCPlus4Out, 32'hC);
        chk("s2_rdy", {31'd0, InReady}, 32'd1);
        step(0, 0, 0, 1, 0, 0);
        chk("s3_valid", {31'd0, OutValid}, 32'd0);

        // 3: backpressure fills the buffer, then drains in order
        step(1, 32'h10, 32'h110, 0, 0, 0);
        step(1, 32'h14, 32'h114, 0, 0, 0);
        chk("full_rdy", {31'd0, InReady}, 32'd0);
        chk("full_head", PCOut, 32'h10);
        step(1, 32'h18, 32'h118, 0, 0, 0);
        chk("hold_head", PCOut, 32'h10);
        step(0, 0, 0, 1, 0, 0);
        chk("drain0", PCOut, 32'h14);
        chk("drain0_ins", InstructionOut, 32'h114);
        step(0, 0, 0, 1, 0, 0);
        chk("drain1_valid", {31'd0, OutValid}, 32'd0);

        // 4: flush while full with a same-cycle fetch of 0x40
        step(1, 32'h20, 32'h120, 0, 0, 0);
        step(1, 32'h24, 32'h124, 0, 0, 0);
        step(1, 32'h40, 32'h140, 0, 1, 0);
        chk("fl_valid", {31'd0, OutValid}, 32'd0);
        chk("fl_rdy", {31'd0, InReady}, 32'd1);
        chk("fl_ins", InstructionOut, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        chk("fl_after", {31'd0, OutValid}, 32'd0);

        // 5: PC+4 wraps at the top of the address space
        step(1, 32'hFFFF_FFFC, 32'h77, 1, 0, 0);
        chk("wrap_pc", PCOut, 32'hFFFF_FFFC);
        chk("wrap_pp4", PCPlus4Out, 32'h0);
        step(0, 0, 0, 1, 0, 0);

        // 6: reset while full, then resume
        step(1, 32'h30, 32'h130, 0, 0, 0);
        step(1, 32'h34, 32'h134, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("r6_valid", {31'd0, OutValid}, 32'd0);
        chk("r6_pc", PCOut, 32'h0);
        chk("r6_pp4", PCPlus4Out, 32'h0);
        chk("r6_ins", InstructionOut, 32'h0);
        step(1, 32'h80, 32'h180, 1, 0, 0);
        chk("r6_resume", PCOut, 32'h80);
        chk("r6_resume_pp4", PCPlus4Out, 32'h84);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom & 32'hFFFF_FFFC,
                 $urandom,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        @(negedge Clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_if_id_stage_buffer
`default_nettype wire
